// File: rtl/nibble_addsub_pkg.sv
// Shared types and constants for the nibble-serial add/subtract sequencer.
package nibble_addsub_pkg;

  localparam int unsigned NIBBLE_W = 4;

  localparam logic OP_ADD = 1'b0;
  localparam logic OP_SUB = 1'b1;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_e;

endpackage

// File: rtl/nibble_addsub_slice.sv
// Combinational 4-bit adder slice; inv selects ~y so one slice serves add and subtract.
module nibble_addsub_slice
  import nibble_addsub_pkg::*;
(
  input  logic [NIBBLE_W-1:0] x,
  input  logic [NIBBLE_W-1:0] y,
  input  logic                inv,
  input  logic                cin,
  output logic [NIBBLE_W-1:0] s,
  output logic                cout
);

  logic [NIBBLE_W-1:0] y_eff;
  logic [NIBBLE_W:0]   sum;

  always_comb begin
    y_eff = inv ? ~y : y;
    sum   = {1'b0, x} + {1'b0, y_eff} + {{NIBBLE_W{1'b0}}, cin};
  end

  assign s    = sum[NIBBLE_W-1:0];
  assign cout = sum[NIBBLE_W];

endmodule

// File: rtl/nibble_addsub_sequencer.sv
// Multi-cycle add/subtract: one shared 4-bit slice walks the operands LSB nibble first,
// with the carry held in a register between nibbles.
module nibble_addsub_sequencer
  import nibble_addsub_pkg::*;
#(
  parameter int unsigned NIBBLES = 4
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        start,
  input  logic                        op,
  input  logic                        c_i,
  input  logic [NIBBLE_W*NIBBLES-1:0] a,
  input  logic [NIBBLE_W*NIBBLES-1:0] b,
  output logic [NIBBLE_W*NIBBLES-1:0] result,
  output logic                        c_o,
  output logic                        zero,
  output logic                        ovf,
  output logic                        busy,
  output logic                        done
);

  localparam int unsigned W    = NIBBLE_W * NIBBLES;
  localparam int unsigned IdxW = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;

  state_e            state_q, state_d;
  logic [W-1:0]      a_q, b_q, result_q, result_nxt;
  logic              op_q, carry_q, c_o_q, zero_q, ovf_q;
  logic [IdxW-1:0]   idx_q;
  logic              load, last, b_eff_msb;
  logic [NIBBLE_W-1:0] slice_x, slice_y, slice_s;
  logic              slice_cout;

  assign load = start && (state_q == IDLE || state_q == DONE);
  assign last = (idx_q == IdxW'(NIBBLES - 1));

  assign slice_x = a_q[idx_q*NIBBLE_W +: NIBBLE_W];
  assign slice_y = b_q[idx_q*NIBBLE_W +: NIBBLE_W];

  nibble_addsub_slice u_slice (
    .x    (slice_x),
    .y    (slice_y),
    .inv  (op_q == OP_SUB),
    .cin  (carry_q),
    .s    (slice_s),
    .cout (slice_cout)
  );

  // Result with the current nibble merged in; flags are judged on this final value.
  always_comb begin
    result_nxt = result_q;
    result_nxt[idx_q*NIBBLE_W +: NIBBLE_W] = slice_s;
  end

  assign b_eff_msb = (op_q == OP_ADD) ? b_q[W-1] : ~b_q[W-1];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (start) state_d = RUN;
      RUN:     if (last) state_d = DONE;
      DONE:    state_d = start ? RUN : IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    busy = (state_q == RUN);
    done = (state_q == DONE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_q      <= '0;
      b_q      <= '0;
      op_q     <= 1'b0;
      idx_q    <= '0;
      carry_q  <= 1'b0;
      result_q <= '0;
      c_o_q    <= 1'b0;
      zero_q   <= 1'b0;
      ovf_q    <= 1'b0;
    end else if (load) begin
      a_q     <= a;
      b_q     <= b;
      op_q    <= op;
      idx_q   <= '0;
      carry_q <= (op == OP_SUB) ? 1'b1 : c_i;
    end else if (state_q == RUN) begin
      result_q <= result_nxt;
      carry_q  <= slice_cout;
      idx_q    <= last ? '0 : idx_q + 1'b1;
      if (last) begin
        c_o_q  <= slice_cout;
        zero_q <= (result_nxt == '0);
        ovf_q  <= (a_q[W-1] == b_eff_msb) && (result_nxt[W-1] != a_q[W-1]);
      end
    end
  end

  assign result = result_q;
  assign c_o    = c_o_q;
  assign zero   = zero_q;
  assign ovf    = ovf_q;

endmodule

// File: doc/nibble_addsub_sequencer.md
# nibble_addsub_sequencer

Multi-cycle add/subtract controller that time-shares a single 4-bit adder/subtractor slice across a wider operand, one nibble per clock, LSB nibble first. The carry is held in a register between nibbles. Start/Done handshake toward the issuing logic; Result and flags are held stable after completion. Sits between the operand registers of the arithmetic path and the single nibble datapath, and replaces a full-width ripple adder where area matters more than latency.

## Interface
- NIBBLES, default 4: number of 4-bit slices; operand width W = 4*NIBBLES (minimum 2).
- Clk  input  1  rising-edge clock; the only clock.
- Rst_n  input  1  asynchronous, active-low reset.
- Start  input  1  request; sampled only in IDLE or DONE.
- Op  input  1  0 = add (A + B + C_i), 1 = subtract (A + ~B + 1); latched at Start.
- C_i  input  1  carry-in for add; ignored for subtract; latched at Start.
- A  input  W  operand A; latched at Start.
- B  input  W  operand B; latched at Start.
- Result  output  W  sum/difference; built nibble by nibble; final once Done is high.
- C_o  output  1  final carry-out. For subtract, 1 = no borrow (A >= B unsigned).
- Zero  output  1  Result == 0; valid with Done.
- Ovf  output  1  signed overflow; valid with Done.
- Busy  output  1  high while state is RUN.
- Done  output  1  one-cycle pulse; Result and flags are valid.

## Operation
- Reset (asynchronous, any state): state IDLE. Result, C_o, Zero, Ovf, Busy, Done, nibble index and carry register all 0.
- State machine:
  - IDLE --Start--> RUN: latch A, B, Op, C_i; index = 0; carry register = Op ? 1 : C_i.
  - RUN: each cycle, the slice computes A[idx] + (Op ? ~B[idx] : B[idx]) + carry.
    - The sum is written to Result[4*idx+3:4*idx]; the slice carry-out goes to the carry register; idx increments.
    - On idx == NIBBLES-1, go to DONE.
  - DONE: Done = 1 for exactly one cycle.
    - Start high in DONE: latch the new operands and go to RUN (back-to-back issue).
    - Otherwise go to IDLE.
- Start while in RUN is ignored; there is no queueing.
- Operand inputs may change freely after the Start cycle.
- C_o = carry register after the last nibble.
- Zero = (Result == 0), registered when entering DONE.
- Ovf = (A[W-1] == Beff[W-1]) && (Result[W-1] != A[W-1]), where Beff = Op ? ~B : B.
- Outputs hold their values in IDLE until the next Start. Upper nibbles of Result are not cleared at Start; they are overwritten during RUN.
- All arithmetic is modulo 2^W. Carries beyond bit W-1 appear only on C_o.

## Timing
- Start sampled at edge E0.
- Nibble k is registered at edge E(k+1).
- DONE is entered at E(NIBBLES); Done is high from E(NIBBLES) to E(NIBBLES+1).
- Latency is NIBBLES+1 edges from Start to the end of the Done pulse.
- Throughput: one operation every NIBBLES+1 cycles with back-to-back Start.
- Busy is high from E1 to E(NIBBLES). Busy and Done are never high together.
- Reset asserted mid-RUN: all outputs clear immediately (asynchronous). After reset release, the first Start is accepted on the next edge.

## Structure
- Package nibble_addsub_pkg holds:
  - state enum {IDLE, RUN, DONE};
  - OP_ADD = 1'b0 and OP_SUB = 1'b1;
  - NIBBLE_W = 4.
- One sub-module, nibble_addsub_slice: purely combinational. Inputs x[3:0], y[3:0], inv, cin; outputs s[3:0], cout. The slice applies the B inversion internally, and the controller instantiates it exactly once.
- The controller holds the FSM, the operand/index/carry registers and the flag logic.

## Test plan
- Add, NIBBLES=4: A=16'h1234, B=16'h0FFF, C_i=0.
  - Done four edges after the Start edge; Result=16'h2233, C_o=0, Zero=0, Ovf=0.
  - Busy high for exactly 4 cycles.
- Subtract equal operands: A=B=16'hABCD.
  - Result=0, Zero=1, C_o=1, Ovf=0.
- Subtract with borrow and signed overflow: A=16'h8000, B=16'h0001.
  - Result=16'h7FFF, C_o=1, Ovf=1.
  - Then A=16'h0001, B=16'h0002: Result=16'hFFFF, C_o=0, Ovf=0.
- Add with carry-in and wrap: A=16'hFFFF, B=16'h0000, C_i=1.
  - Result=0, C_o=1, Zero=1.
  - Changing A during RUN does not alter the result.
- Back-to-back and ignored Start:
  - Start held high continuously: Done pulses every 5 cycles.
  - Start pulsed mid-RUN: no effect.
- Reset mid-RUN: Rst_n low after nibble 1.
  - All outputs are 0 before the next clock edge.
  - Done does not assert; a new Start afterwards completes normally.
